// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and
// the decode-side valid/ready handshake.
interface inst_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    modport master (
        output imem_req_valid,
        output imem_addr,
        output id_valid,
        output id_inst,
        output id_pc,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        input  id_valid,
        input  id_inst,
        input  id_pc,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        output id_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited in-order requests, PC pairing FIFO,
// instruction queue to decode, redirect flush with drain of stale responses.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    inst_fetch_if.master bus
);
    localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

    typedef enum logic [1:0] {RESET_WAIT, RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [31:2]   fpc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt, discard_next;
    logic [CW-1:0] q_count;
    logic [CW-1:0] rsp_cnt;
    logic [CW:0]   credit_used;
    logic [PW-1:0] pf_wr, pf_rd, q_head, q_tail;
    logic [31:2]   pf_mem [FQ_DEPTH];
    logic [31:2]   q_pc   [FQ_DEPTH];
    logic [31:0]   q_inst [FQ_DEPTH];
    logic          accept, rsp, drop, push, pop, redirect;
    logic          unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign unused_bits = ^bus.redirect_pc[1:0];

    // A response with nothing outstanding belongs to a request abandoned by reset.
    assign rsp         = bus.imem_rsp_valid && (outstanding != '0);
    assign rsp_cnt     = CW'(rsp);
    assign redirect    = bus.redirect_valid;
    assign credit_used = {1'b0, q_count} + {1'b0, outstanding};

    assign bus.imem_req_valid = (state == RUN) && (credit_used < (CW+1)'(FQ_DEPTH)) && !redirect;
    assign bus.imem_addr      = {fpc, 2'b00};
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;

    assign drop = rsp && (discard_cnt != '0);
    assign push = rsp && (discard_cnt == '0) && !redirect;
    assign pop  = bus.id_valid && bus.id_ready;

    assign bus.id_valid = (q_count != '0);
    assign bus.id_inst  = bus.id_valid ? q_inst[q_head] : '0;
    assign bus.id_pc    = bus.id_valid ? {q_pc[q_head], 2'b00} : '0;

    always_comb begin
        discard_next = discard_cnt;
        state_next   = state;
        if (redirect)
            discard_next = outstanding - rsp_cnt;
        else if (drop)
            discard_next = discard_cnt - CW'(1);

        unique case (state)
            RESET_WAIT: state_next = RUN;
            RUN:        if (redirect && (discard_next != '0)) state_next = DRAIN;
            DRAIN:      if (!redirect && (discard_next == '0)) state_next = RUN;
            default:    state_next = RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RESET_WAIT;
            fpc         <= RESET_PC[31:2];
            outstanding <= '0;
            discard_cnt <= '0;
            pf_wr       <= '0;
            pf_rd       <= '0;
        end else begin
            state       <= state_next;
            discard_cnt <= discard_next;
            outstanding <= outstanding + CW'(accept) - rsp_cnt;
            if (redirect)
                fpc <= bus.redirect_pc[31:2];
            else if (accept)
                fpc <= fpc + 30'd1;
            if (accept)
                pf_wr <= ptr_inc(pf_wr);
            // Discarded responses still retire their PC entry to keep pairing aligned.
            if (rsp)
                pf_rd <= ptr_inc(pf_rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else if (redirect) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else begin
            if (push)
                q_tail <= ptr_inc(q_tail);
            if (pop)
                q_head <= ptr_inc(q_head);
            q_count <= q_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pf_mem[pf_wr] <= fpc;
        if (push) begin
            q_inst[q_tail] <= bus.imem_rsp_data;
            q_pc[q_tail]   <= pf_mem[pf_rd];
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: in-order memory model with variable latency,
// expected PC stream restarted on every reset/redirect.
module tb_inst_fetch;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_w_n;
    always #5 clk = ~clk;

    inst_fetch_if ifc ();
    inst_fetch_if ifw ();

    inst_fetch #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc));
    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_w_n), .bus(ifw));

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    int          hs_cyc[$];
    int          n_cmp = 0, n_err = 0;
    int          cyc, last_due, delay_min, delay_max;
    int          n_hs = 0, n_acc = 0, n_rsp = 0;
    bit          ready_rand, idr_rand, ready_fix, idr_fix;
    bit          redir_req, last_redir, stale_rsp;
    logic [31:0] redir_target, last_acc_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A3C_96E1;
    endfunction

    task automatic seed(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 4; i++)
            exp_q.push_back({start[31:2], 2'b00} + 32'(4 * i));
    endtask

    // One clock: drive at the falling edge, sample 1ns later, score handshakes.
    task automatic step();
        int          d;
        int          due;
        logic [31:0] e;
        @(negedge clk);
        rst_n = 1'b1;
        ifc.imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
        ifc.id_ready       = idr_rand ? 1'($urandom_range(0, 1)) : idr_fix;
        ifc.redirect_valid = redir_req;
        ifc.redirect_pc    = redir_target;
        if (stale_rsp) begin
            ifc.imem_rsp_valid = 1'b1;
            ifc.imem_rsp_data  = 32'hBAD0_BAD0;
            stale_rsp = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            ifc.imem_rsp_valid = 1'b1;
            ifc.imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
            n_rsp++;
        end else begin
            ifc.imem_rsp_valid = 1'b0;
            ifc.imem_rsp_data  = $urandom;
        end
        #1;
        if (last_redir)
            check("flush_id_valid", 32'(ifc.id_valid), 32'd0);
        last_redir = 1'b0;
        if (ifc.imem_req_valid && ifc.imem_req_ready) begin
            d   = $urandom_range(delay_min, delay_max);
            due = cyc + d;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: ifc.imem_addr, due: due});
            n_acc++;
            last_acc_addr = ifc.imem_addr;
        end
        if (ifc.id_valid && ifc.id_ready) begin
            hs_cyc.push_back(cyc);
            n_hs++;
            e = exp_q.pop_front();
            exp_q.push_back(exp_q[$] + 32'd4);
            check("id_pc", ifc.id_pc, e);
            check("id_inst", ifc.id_inst, mem_word(e));
        end
        if (redir_req) begin
            seed(redir_target);
            redir_req  = 1'b0;
            last_redir = 1'b1;
        end
        cyc++;
    endtask

    task automatic prep_release();
        pend.delete();
        cyc      = 0;
        last_due = -1;
        seed(32'h0000_0000);
    endtask

    logic [31:0] w_got[$];
    logic [31:0] w_exp[$];
    logic [31:0] w_prev, held;
    bit          w_acc, have;
    int          acc_before, rsp_before, hs_before;

    initial begin
        rst_n = 1'b0; rst_w_n = 1'b0;
        ready_rand = 0; idr_rand = 0; ready_fix = 1; idr_fix = 1;
        redir_req = 0; last_redir = 0; stale_rsp = 0; redir_target = '0;
        delay_min = 1; delay_max = 1; cyc = 0; last_due = -1;
        ifc.imem_req_ready = 1'b0; ifc.imem_rsp_valid = 1'b0; ifc.imem_rsp_data = '0;
        ifc.redirect_valid = 1'b0; ifc.redirect_pc = '0; ifc.id_ready = 1'b0;
        ifw.imem_req_ready = 1'b1; ifw.imem_rsp_valid = 1'b0; ifw.imem_rsp_data = '0;
        ifw.redirect_valid = 1'b0; ifw.redirect_pc = '0; ifw.id_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        check("rst_addr", ifc.imem_addr, 32'h0000_0000);
        check("rst_id_valid", 32'(ifc.id_valid), 32'd0);
        check("rst_id_inst", ifc.id_inst, 32'd0);
        check("rst_id_pc", ifc.id_pc, 32'd0);
        check("rst_addr_w", ifw.imem_addr, 32'hFFFF_FFF8);

        // Address wrap from a high reset PC (second instance, default depth).
        w_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        w_acc = 1'b0; w_prev = '0;
        @(negedge clk);
        rst_w_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            ifw.imem_rsp_valid = w_acc;
            ifw.imem_rsp_data  = mem_word(w_prev);
            #1;
            w_acc = ifw.imem_req_valid && ifw.imem_req_ready;
            if (w_acc) begin
                w_prev = ifw.imem_addr;
                w_got.push_back(ifw.imem_addr);
            end
        end
        while (w_exp.size() > 0)
            check("wrap_addr", (w_got.size() > 0) ? w_got.pop_front() : 32'hDEAD_BEEF,
                  w_exp.pop_front());

        // Streaming from reset: first instruction three cycles after release.
        prep_release();
        hs_cyc.delete();
        repeat (12) step();
        for (int i = 0; i < 4; i++)
            check("stream_cycle", (hs_cyc.size() > i) ? 32'(hs_cyc[i]) : 32'hFFFF_FFFF,
                  32'(3 + i));

        // Redirect with exactly two requests in flight.
        ready_fix = 0;
        repeat (8) step();
        delay_min = 4; delay_max = 4; ready_fix = 1;
        repeat (2) step();
        ready_fix = 0;
        check("redir_outstanding", 32'(pend.size()), 32'd2);
        redir_req = 1; redir_target = 32'h0000_0102;
        rsp_before = n_rsp; acc_before = n_acc;
        delay_min = 1; delay_max = 1; ready_fix = 1;
        step();
        for (int i = 0; i < 20 && n_acc == acc_before; i++) step();
        check("redir_accepted", 32'(n_acc != acc_before), 32'd1);
        check("redir_discarded", 32'(n_rsp - rsp_before), 32'd2);
        check("redir_next_addr", last_acc_addr, 32'h0000_0100);
        hs_before = n_hs;
        repeat (6) step();
        check("redir_progress", 32'(n_hs > hs_before), 32'd1);

        // Fill the queue, redirect while decode accepts, then stall decode.
        idr_fix = 0;
        repeat (8) step();
        hs_before = n_hs;
        idr_fix = 1; redir_req = 1; redir_target = 32'h0000_0300;
        step();
        check("redir_pop", 32'(n_hs - hs_before), 32'd1);
        idr_fix = 0; acc_before = n_acc; have = 0; held = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ifc.id_valid) begin
                if (!have) begin
                    held = ifc.id_inst;
                    have = 1;
                end else
                    check("stall_hold", ifc.id_inst, held);
            end
            if (i >= 7)
                check("stall_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        end
        check("stall_req_count", 32'(n_acc - acc_before), 32'(DEPTH));
        check("stall_head", held, mem_word(32'h0000_0300));

        // Asynchronous reset with a full queue; stale response after release.
        check("full_id_valid", 32'(ifc.id_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_id_valid", 32'(ifc.id_valid), 32'd0);
        check("async_addr", ifc.imem_addr, 32'h0000_0000);
        check("async_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        repeat (2) @(posedge clk);
        prep_release();
        stale_rsp = 1; idr_fix = 1; ready_fix = 1;
        hs_before = n_hs;
        repeat (15) step();
        check("post_rst_progress", 32'(n_hs > hs_before), 32'd1);

        // Random backpressure, latency 1..4 and occasional redirects.
        ready_rand = 1; idr_rand = 1; delay_min = 1; delay_max = 4;
        hs_before = n_hs;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                redir_req    = 1;
                redir_target = $urandom;
            end
            step();
        end
        check("random_progress", 32'(n_hs - hs_before > 50), 32'd1);
        ready_rand = 0; idr_rand = 0; ready_fix = 1; idr_fix = 1;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
